// File: rtl/trace_dfd_pkg.sv
// Shared types for the DfD trace capture path.
//   trace_state_e : capture sequencer state, encoded IDLE=0, ARMED=1, POST=2, DONE=3
//   TRACE_STATE_W : width of the exported state field
//   clog2()       : elaboration-time address width helper
package trace_dfd_pkg;

    localparam int TRACE_STATE_W = 2;

    typedef enum logic [TRACE_STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_trig_match.sv
// Masked trigger comparator for a trace tap.
//   data  : sampled trace word
//   valid : data is valid this cycle
//   value : trigger compare value
//   mask  : 1 = bit participates in the compare
//   hit   : valid sample matches value on all masked bits
module trace_trig_match #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic         valid,
    input  logic [W-1:0] value,
    input  logic [W-1:0] mask,
    output logic         hit
);

    assign hit = valid & ((data & mask) == (value & mask));

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace memory sequencer: circular capture with pre-trigger history, a
// programmable post-trigger window, freeze, then oldest-to-newest readout.
//   clk, reset                 : clock, synchronous active-high reset
//   arm, abort                 : start capture (IDLE/DONE), return to IDLE
//   trig_value, trig_mask      : trigger compare
//   post_count                 : samples kept after the trigger, latched on arm
//   trace_in, trace_valid      : trace tap
//   mem_wr_*, mem_rd_*         : external simple dual-port RAM, 1-cycle read
//   rd_req, rd_data, rd_valid  : debug readout
//   state, triggered, wrapped, entries, trig_addr, rd_left : status
//
// state | meaning
// IDLE  | no capture, memory frozen
// ARMED | storing history, watching for the trigger
// POST  | trigger seen, storing the post-trigger window
// DONE  | capture frozen, readout allowed
module trace_capture_ctrl
    import trace_dfd_pkg::*;
#(
    parameter  int Fpay     = 32,
    parameter  int TB_Depth = 512,
    localparam int TB_Aw    = clog2(TB_Depth)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [Fpay-1:0]          trig_value,
    input  logic [Fpay-1:0]          trig_mask,
    input  logic [TB_Aw-1:0]         post_count,
    input  logic [Fpay-1:0]          trace_in,
    input  logic                     trace_valid,
    output logic                     mem_wr_en,
    output logic [TB_Aw-1:0]         mem_wr_addr,
    output logic [Fpay-1:0]          mem_wr_data,
    output logic                     mem_rd_en,
    output logic [TB_Aw-1:0]         mem_rd_addr,
    input  logic [Fpay-1:0]          mem_rd_data,
    input  logic                     rd_req,
    output logic [Fpay-1:0]          rd_data,
    output logic                     rd_valid,
    output logic [TRACE_STATE_W-1:0] state,
    output logic                     triggered,
    output logic                     wrapped,
    output logic [TB_Aw:0]           entries,
    output logic [TB_Aw-1:0]         trig_addr,
    output logic [TB_Aw:0]           rd_left
);

    localparam logic [TB_Aw:0] DEPTH_W = (TB_Aw+1)'(TB_Depth);

    trace_state_e     st;
    logic [TB_Aw-1:0] wr_ptr;
    logic [TB_Aw-1:0] rd_ptr;
    logic [TB_Aw-1:0] post_cnt;
    logic             hit;
    logic             wr_fire;
    logic             rd_fire;
    logic             can_arm;
    logic [TB_Aw-1:0] wr_ptr_nxt;
    logic             wrapped_nxt;
    logic [TB_Aw:0]   entries_nxt;
    logic [TB_Aw-1:0] oldest_nxt;

    trace_trig_match #(.W(Fpay)) u_match (
        .data  (trace_in),
        .valid (trace_valid),
        .value (trig_value),
        .mask  (trig_mask),
        .hit   (hit)
    );

    // Reset and abort both outrank a write; arm and abort outrank a read.
    assign wr_fire = ~reset & ~abort & trace_valid & ((st == ST_ARMED) | (st == ST_POST));
    assign rd_fire = ~reset & ~abort & ~arm & rd_req & (st == ST_DONE) & (rd_left != '0);
    assign can_arm = (st == ST_IDLE) | (st == ST_DONE);

    assign wr_ptr_nxt  = wr_ptr + 1'b1;
    assign wrapped_nxt = wrapped | (&wr_ptr);
    assign entries_nxt = (entries == DEPTH_W) ? entries : entries + 1'b1;
    // After the final write, the oldest entry sits at the new write pointer once wrapped.
    assign oldest_nxt  = wrapped_nxt ? wr_ptr_nxt : '0;

    assign mem_wr_en   = wr_fire;
    assign mem_wr_addr = wr_ptr;
    assign mem_wr_data = trace_in;
    assign mem_rd_en   = rd_fire;
    assign mem_rd_addr = rd_ptr;
    assign rd_data     = mem_rd_data;
    assign state       = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            entries   <= '0;
            rd_left   <= '0;
            trig_addr <= '0;
            triggered <= 1'b0;
            wrapped   <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            // A read issued last cycle is always delivered, even across abort/arm.
            rd_valid <= rd_fire;
            if (abort) begin
                st <= ST_IDLE;
            end else if (arm && can_arm) begin
                st        <= ST_ARMED;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                entries   <= '0;
                rd_left   <= '0;
                trig_addr <= '0;
                triggered <= 1'b0;
                wrapped   <= 1'b0;
                post_cnt  <= post_count;
            end else begin
                if (wr_fire) begin
                    wr_ptr  <= wr_ptr_nxt;
                    entries <= entries_nxt;
                    wrapped <= wrapped_nxt;
                end
                case (st)
                    ST_ARMED: begin
                        if (wr_fire && hit) begin
                            trig_addr <= wr_ptr;
                            triggered <= 1'b1;
                            if (post_cnt == '0) begin
                                st      <= ST_DONE;
                                rd_ptr  <= oldest_nxt;
                                rd_left <= entries_nxt;
                            end else begin
                                st <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (wr_fire) begin
                            post_cnt <= post_cnt - 1'b1;
                            if (post_cnt == TB_Aw'(1)) begin
                                st      <= ST_DONE;
                                rd_ptr  <= oldest_nxt;
                                rd_left <= entries_nxt;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (rd_fire) begin
                            rd_ptr  <= rd_ptr + 1'b1;
                            rd_left <= rd_left - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl with an 8-entry trace memory.
// The reference keeps the whole stream of accepted samples in a queue; the
// expected memory picture is simply the last min(N, depth) samples, with
// stream index j living at address j mod depth.
module tb_trace_capture_ctrl;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic          abort;
    logic [W-1:0]  trig_value;
    logic [W-1:0]  trig_mask;
    logic [AW-1:0] post_count;
    logic [W-1:0]  trace_in;
    logic          trace_valid;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [W-1:0]  mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_rd_data;
    logic          rd_req;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [1:0]    state;
    logic          triggered;
    logic          wrapped;
    logic [AW:0]   entries;
    logic [AW-1:0] trig_addr;
    logic [AW:0]   rd_left;

    always #5 clk = ~clk;

    trace_capture_ctrl #(.Fpay(W), .TB_Depth(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .abort       (abort),
        .trig_value  (trig_value),
        .trig_mask   (trig_mask),
        .post_count  (post_count),
        .trace_in    (trace_in),
        .trace_valid (trace_valid),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .state       (state),
        .triggered   (triggered),
        .wrapped     (wrapped),
        .entries     (entries),
        .trig_addr   (trig_addr),
        .rd_left     (rd_left)
    );

    // Simple dual-port RAM, 1-cycle read latency.
    logic [W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] m_q [$];
    bit           m_trig;
    bit           m_done;
    int           m_rem;
    int           m_trig_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int stored(input int len);
        return (len < DEPTH) ? len : DEPTH;
    endfunction

    // mode 0: valid every cycle, data 1,2,3..  mode 1: random valid and data
    // mode 2: constant 0xAA                    mode 3: counting data, valid every other cycle
    task automatic capture(input int post, input logic [W-1:0] val, input logic [W-1:0] msk,
                           input int mode, input int nmax, input bit expect_done);
        logic         v;
        logic [W-1:0] d;
        int           k;
        int           cyc;
        trig_value = val;
        trig_mask  = msk;
        post_count = AW'(post);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        m_q.delete();
        m_trig = 0;
        m_done = 0;
        m_rem = post;
        m_trig_idx = 0;
        k = 1;
        cyc = 0;
        while (!m_done && cyc < nmax) begin
            chk("cap_state", state, m_trig ? 2 : 1);
            case (mode)
                0:       begin v = 1'b1; d = W'(k); end
                1:       begin v = 1'($urandom_range(0, 1)); d = $urandom; end
                2:       begin v = 1'b1; d = 32'hAA; end
                default: begin v = 1'((cyc % 2) == 0); d = W'(k); end
            endcase
            if (v) k++;
            trace_valid = v;
            trace_in = d;
            #1;
            chk("wr_en", mem_wr_en, v);
            if (v) begin
                chk("wr_addr", mem_wr_addr, m_q.size() % DEPTH);
                m_q.push_back(d);
                if (!m_trig) begin
                    if ((d & msk) == (val & msk)) begin
                        m_trig = 1;
                        m_trig_idx = m_q.size() - 1;
                        if (post == 0) m_done = 1;
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_done = 1;
                end
            end
            tick();
            cyc++;
        end
        trace_valid = 1'b0;
        if (expect_done) chk("capture_done", m_done, 1);
        if (m_done) begin
            chk("done_state", state, 3);
            chk("triggered", triggered, 1);
            chk("wrapped", wrapped, m_q.size() >= DEPTH);
            chk("entries", entries, stored(m_q.size()));
            chk("trig_addr", trig_addr, m_trig_idx % DEPTH);
            chk("rd_left_init", rd_left, stored(m_q.size()));
            trace_valid = 1'b1;
            #1;
            chk("no_wr_in_done", mem_wr_en, 0);
            trace_valid = 1'b0;
        end else if (!expect_done) begin
            chk("partial_state", state, m_trig ? 2 : 1);
        end
    endtask

    task automatic readout(input int n_req);
        int len;
        int exp_n;
        int base;
        len = m_q.size();
        exp_n = stored(len);
        base = len - exp_n;
        for (int i = 0; i <= n_req; i++) begin
            rd_req = (i < n_req);
            #1;
            chk("rd_en", mem_rd_en, (i < n_req) && (i < exp_n));
            if ((i < n_req) && (i < exp_n)) chk("rd_addr", mem_rd_addr, (base + i) % DEPTH);
            chk("rd_valid", rd_valid, (i > 0) && (i - 1 < exp_n));
            if ((i > 0) && (i - 1 < exp_n)) chk("rd_data", rd_data, m_q[base + i - 1]);
            tick();
        end
        rd_req = 1'b0;
        chk("rd_left_end", rd_left, (exp_n > n_req) ? exp_n - n_req : 0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_entries"}, entries, 0);
        chk({tag, "_rd_left"}, rd_left, 0);
        chk({tag, "_trig_addr"}, trig_addr, 0);
        chk({tag, "_triggered"}, triggered, 0);
        chk({tag, "_wrapped"}, wrapped, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rmask;
        reset = 1'b1;
        arm = 1'b0;
        abort = 1'b0;
        trig_value = '0;
        trig_mask = '0;
        post_count = '0;
        trace_in = '0;
        trace_valid = 1'b0;
        rd_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_cleared("reset");
        trace_valid = 1'b1;
        rd_req = 1'b1;
        #1;
        chk("idle_no_wr", mem_wr_en, 0);
        chk("idle_no_rd", mem_rd_en, 0);
        trace_valid = 1'b0;
        rd_req = 1'b0;

        // Trigger without wrap, then read past the end.
        capture(2, 32'h05, 32'hFF, 0, 50, 1);
        readout(9);

        // Trigger after the pointer wraps; readout starts mid-memory.
        capture(2, 32'h0C, 32'hFF, 0, 50, 1);
        readout(10);

        // Mask 0, no post window: first valid sample triggers and ends capture.
        capture(0, 32'h55, 32'h0, 2, 10, 1);
        readout(2);

        // Longest post window: pre-trigger history gets overwritten.
        capture(7, 32'h03, 32'hFF, 0, 50, 1);
        readout(9);

        // Gapped valid during POST.
        capture(3, 32'h05, 32'hFF, 3, 50, 1);
        readout(3);

        // arm with a coincident rd_req in DONE: read dropped, re-armed.
        arm = 1'b1;
        rd_req = 1'b1;
        #1;
        chk("arm_rd_no_en", mem_rd_en, 0);
        tick();
        arm = 1'b0;
        rd_req = 1'b0;
        chk("arm_rd_state", state, 1);
        chk("arm_rd_valid", rd_valid, 0);

        // abort from ARMED stops writes.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", state, 0);
        trace_valid = 1'b1;
        trace_in = 32'h05;
        #1;
        chk("abort_no_wr", mem_wr_en, 0);
        tick();
        trace_valid = 1'b0;
        chk("abort_stay_idle", state, 0);

        // Reset in the middle of the post window.
        capture(5, 32'h02, 32'hFF, 0, 4, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("rst_post");

        // abort with a read in flight: the word still arrives.
        capture(1, 32'h03, 32'hFF, 0, 50, 1);
        rd_req = 1'b1;
        #1;
        chk("flight_rd_en", mem_rd_en, 1);
        tick();
        rd_req = 1'b0;
        abort = 1'b1;
        #1;
        chk("abort_flight_valid", rd_valid, 1);
        chk("abort_flight_data", rd_data, m_q[m_q.size() - stored(m_q.size())]);
        tick();
        abort = 1'b0;
        chk("abort_flight_state", state, 0);
        chk("abort_flight_after", rd_valid, 0);

        // Reset with a read in flight and another requested.
        capture(1, 32'h03, 32'hFF, 0, 50, 1);
        rd_req = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        chk("rst_rd_no_en", mem_rd_en, 0);
        tick();
        reset = 1'b0;
        rd_req = 1'b0;
        check_cleared("rst_read");

        // Randomised captures against the stream model.
        for (int t = 0; t < 6; t++) begin
            rmask = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
            capture($urandom_range(0, 7), $urandom, rmask, 1, 400, 1);
            readout($urandom_range(1, 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
